// File: rtl/uart_pkg.sv
// Shared UART types and constants.
// Receiver and transmitter state encodings live here.
package uart_pkg;

    localparam int unsigned DEFAULT_CYCLES_PER_BIT = 10416;

    typedef logic [2:0] rx_state_t;

    localparam rx_state_t RX_IDLE      = 3'd0;
    localparam rx_state_t RX_START     = 3'd1;
    localparam rx_state_t RX_DATA      = 3'd2;
    localparam rx_state_t RX_STOP      = 3'd3;
    localparam rx_state_t RX_WAIT_HIGH = 3'd4;

    typedef logic [1:0] tx_state_t;

    localparam tx_state_t TX_IDLE  = 2'd0;
    localparam tx_state_t TX_START = 2'd1;
    localparam tx_state_t TX_DATA  = 2'd2;
    localparam tx_state_t TX_STOP  = 2'd3;

    // Last count of the half-bit wait used to land on mid-bit.
    function automatic logic [15:0] half_last(input int unsigned cpb);
        return 16'(cpb / 2 - 1);
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Flop-chain synchroniser for an asynchronous input.
// Resets to 1 so an idle-high line reads idle.
module uart_rx_sync
    import uart_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic i_reset_n,
    input  logic i_async,
    output logic rx_s
);

    logic [SYNC_STAGES-1:0] chain_q;

    // Shift the async input through the chain.
    always_ff @(posedge clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            chain_q <= '1;
        end else begin
            chain_q <= {chain_q[SYNC_STAGES-2:0], i_async};
        end
    end

    assign rx_s = chain_q[SYNC_STAGES-1];

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: start detect, mid-bit sampling,
// one-cycle valid / framing-error pulses.
module uart_receiver
    import uart_pkg::*;
#(
    parameter int unsigned CYCLES_PER_BIT = DEFAULT_CYCLES_PER_BIT,
    parameter int unsigned SYNC_STAGES    = 2
) (
    input  logic       clk,
    input  logic       i_reset_n,
    input  logic       i_rx,
    output logic [0:7] o_data,
    output logic       o_valid,
    output logic       o_frame_error,
    output logic       o_busy
);

    localparam logic [15:0] HALF_LAST = half_last(CYCLES_PER_BIT);
    localparam logic [15:0] BIT_LAST  = 16'(CYCLES_PER_BIT - 1);

    logic rx_s;

    uart_rx_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk      (clk),
        .i_reset_n(i_reset_n),
        .i_async  (i_rx),
        .rx_s     (rx_s)
    );

    rx_state_t              state_q, state_d;
    logic [15:0]            cnt_q, cnt_d;
    logic [2:0]             bit_q, bit_d;
    logic [7:0]             shift_q, shift_d;
    logic [7:0]             data_q, data_d;
    logic                   valid_q, valid_d;
    logic                   ferr_q, ferr_d;
    logic                   prev_q;
    logic [SYNC_STAGES-1:0] arm_q;
    logic                   armed;
    logic                   fall;

    // rx_s only reflects the real line once the chain has flushed
    // its reset value; edges are tracked from then on, so a line
    // held low across reset is not mistaken for a start bit.
    assign armed = arm_q[SYNC_STAGES-1];
    assign fall  = armed & prev_q & ~rx_s;

    // Next-state and datapath.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            RX_IDLE: begin
                if (fall) begin
                    state_d = RX_START;
                    cnt_d   = '0;
                end
            end
            RX_START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = rx_s ? RX_IDLE : RX_DATA;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            RX_DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    shift_d = {rx_s, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = RX_STOP;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            RX_STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                        state_d = RX_IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = RX_WAIT_HIGH;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            RX_WAIT_HIGH: begin
                if (rx_s) begin
                    state_d = RX_IDLE;
                end
            end
            default: begin
                state_d = RX_IDLE;
            end
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            prev_q  <= 1'b0;
            arm_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            arm_q   <= {arm_q[SYNC_STAGES-2:0], 1'b1};
            if (armed) begin
                prev_q <= rx_s;
            end
        end
    end

    assign o_data        = data_q;
    assign o_valid       = valid_q;
    assign o_frame_error = ferr_q;
    assign o_busy        = (state_q != RX_IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver at CYCLES_PER_BIT=16.
// Frames are driven by a behavioural 8N1 transmitter.
module tb_uart_receiver;

    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       i_reset_n = 1'b0;
    logic       i_rx = 1'b1;
    logic [0:7] o_data;
    logic       o_valid;
    logic       o_frame_error;
    logic       o_busy;

    int checks = 0;
    int failures = 0;
    int vcnt = 0;
    int fcnt = 0;
    int both = 0;
    logic [7:0] rxq[$];
    logic [7:0] sent[16];

    always #5 clk = ~clk;

    uart_receiver #(
        .CYCLES_PER_BIT(CPB),
        .SYNC_STAGES   (2)
    ) dut (
        .clk          (clk),
        .i_reset_n    (i_reset_n),
        .i_rx         (i_rx),
        .o_data       (o_data),
        .o_valid      (o_valid),
        .o_frame_error(o_frame_error),
        .o_busy       (o_busy)
    );

    // Record output pulses away from the active edge.
    always @(negedge clk) begin
        if (o_valid) begin
            vcnt++;
            rxq.push_back(o_data);
        end
        if (o_frame_error) fcnt++;
        if (o_valid && o_frame_error) both++;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        i_rx = b;
        tick(CPB);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(stop);
    endtask

    initial begin
        tick(3);
        chk("rst_data", o_data, 0);
        chk("rst_valid", o_valid, 0);
        chk("rst_ferr", o_frame_error, 0);
        chk("rst_busy", o_busy, 0);
        i_reset_n = 1'b1;
        tick(4);

        send_frame(8'hA5, 1'b1);
        tick(2 * CPB);
        chk("a5_vcnt", vcnt, 1);
        chk("a5_data", o_data, 8'hA5);
        chk("a5_ferr", fcnt, 0);

        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        tick(2 * CPB);
        chk("b2b_vcnt", vcnt, 3);
        chk("b2b_first", (rxq.size() > 1) ? rxq[1] : 8'h55, 8'h00);
        chk("b2b_second", (rxq.size() > 2) ? rxq[2] : 8'h55, 8'hFF);
        chk("b2b_data", o_data, 8'hFF);

        i_rx = 1'b0;
        tick(3);
        i_rx = 1'b1;
        tick(3);
        chk("glitch_busy_mid", o_busy, 1);
        tick(12);
        chk("glitch_busy_end", o_busy, 0);
        chk("glitch_vcnt", vcnt, 3);
        chk("glitch_ferr", fcnt, 0);

        send_frame(8'h3C, 1'b0);
        i_rx = 1'b1;
        tick(2 * CPB);
        chk("ferr_cnt", fcnt, 1);
        chk("ferr_vcnt", vcnt, 3);
        chk("ferr_data_kept", o_data, 8'hFF);
        chk("ferr_busy", o_busy, 0);

        i_rx = 1'b0;
        tick(40 * CPB);
        chk("break_busy", o_busy, 1);
        chk("break_ferr", fcnt, 2);
        i_rx = 1'b1;
        tick(2 * CPB);
        chk("break_idle", o_busy, 0);
        send_frame(8'h5A, 1'b1);
        tick(2 * CPB);
        chk("after_break_data", o_data, 8'h5A);
        chk("after_break_vcnt", vcnt, 4);

        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        i_rx = 1'b0;
        tick(8);
        i_reset_n = 1'b0;
        #1;
        chk("midrst_data", o_data, 0);
        chk("midrst_valid", o_valid, 0);
        chk("midrst_ferr", o_frame_error, 0);
        chk("midrst_busy", o_busy, 0);
        tick(3);
        i_reset_n = 1'b1;
        tick(2 * CPB);
        chk("low_after_rst", o_busy, 0);
        i_rx = 1'b1;
        tick(2 * CPB);
        send_frame(8'h81, 1'b1);
        tick(2 * CPB);
        chk("post_rst_data", o_data, 8'h81);
        chk("post_rst_vcnt", vcnt, 5);
        chk("post_rst_ferr", fcnt, 2);

        rxq.delete();
        for (int i = 0; i < 16; i++) begin
            sent[i] = 8'($urandom_range(0, 255));
            send_frame(sent[i], 1'b1);
        end
        tick(2 * CPB);
        chk("loop_count", rxq.size(), 16);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("loop_byte%0d", i),
                (i < rxq.size()) ? {24'd0, rxq[i]} : 32'hDEAD,
                {24'd0, sent[i]});
        end
        chk("loop_ferr", fcnt, 2);
        chk("never_both", both, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
